// File: rtl/pfb_pkg.sv
// rtl/pfb_pkg.sv - shared PFB widths and arm-count helper
package pfb_pkg;

  localparam int unsigned PFB_DATA_W     = 32;
  localparam int unsigned PFB_PHASE_W    = 9;
  localparam int unsigned PFB_MAX_PHASES = 512;

  // Legal arm counts run from 2 up to the phase index range.
  function automatic int unsigned pfb_clamp_phases(input int unsigned n, input int unsigned max_n);
    if (n < 2)
      return 2;
    else if (n > max_n)
      return max_n;
    else
      return n;
  endfunction

endpackage

// File: rtl/pfb_skid_buf.sv
// rtl/pfb_skid_buf.sv - 2-entry registered handshake stage for PFB streams
module pfb_skid_buf #(
  parameter int unsigned WIDTH = 42
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             s_tvalid,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             s_tready,
  output logic             m_tvalid,
  output logic [WIDTH-1:0] m_tdata,
  input  logic             m_tready
);

  logic [1:0]       count;
  logic [1:0]       count_next;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             push;
  logic             pop;

  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;
  assign m_tvalid = (count != 2'd0);
  assign m_tdata  = head;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 2'd1;
    else if (pop && !push)
      count_next = count - 2'd1;
  end

  // head is the output register; tail only holds the beat that arrived during a stall
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      count    <= 2'd0;
      head     <= '0;
      tail     <= '0;
      s_tready <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0)
            head <= s_tdata;
          else
            tail <= s_tdata;
        end
        2'b01: begin
          head <= tail;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= s_tdata;
          end else begin
            head <= s_tdata;
          end
        end
        default: begin
        end
      endcase
      count    <= count_next;
      s_tready <= (count_next != 2'd2);
    end
  end

endmodule

// File: rtl/pfb_input_commutator.sv
// rtl/pfb_input_commutator.sv - tags input samples with descending PFB arm index
module pfb_input_commutator
  import pfb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = PFB_DATA_W,
  parameter int unsigned PHASE_WIDTH = PFB_PHASE_W
) (
  input  logic                   clk,
  input  logic                   sync_reset,
  input  logic [PHASE_WIDTH:0]   num_phases,
  input  logic                   resync,
  input  logic                   s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  output logic                   s_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic [PHASE_WIDTH-1:0] m_phase,
  output logic [15:0]            frame_cnt
);

  localparam int unsigned CNT_W      = PHASE_WIDTH + 1;
  localparam int unsigned MAX_PHASES = 1 << PHASE_WIDTH;
  localparam int unsigned BUF_W      = DATA_WIDTH + PHASE_WIDTH + 1;

  logic [CNT_W-1:0]       active_cnt;
  logic [CNT_W-1:0]       beat_idx;
  logic                   frame_pending;
  logic [CNT_W-1:0]       cur_cnt;
  logic [CNT_W-1:0]       cur_idx;
  logic [PHASE_WIDTH-1:0] beat_phase;
  logic                   beat_last;
  logic                   accept;
  logic [BUF_W-1:0]       buf_out;

  assign accept = s_axis_tvalid & s_axis_tready;

  // A pending frame start samples num_phases on the very beat that opens the frame.
  always_comb begin
    cur_cnt = active_cnt;
    cur_idx = beat_idx;
    if (frame_pending) begin
      cur_cnt = CNT_W'(pfb_clamp_phases(32'(num_phases), MAX_PHASES));
      cur_idx = '0;
    end
  end

  assign beat_phase = PHASE_WIDTH'(cur_cnt - cur_idx - CNT_W'(1));
  assign beat_last  = (cur_idx == cur_cnt - CNT_W'(1));

  // resync never re-phases the beat accepted alongside it, only the next one
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      active_cnt    <= CNT_W'(MAX_PHASES);
      beat_idx      <= '0;
      frame_pending <= 1'b1;
    end else begin
      if (accept) begin
        active_cnt <= cur_cnt;
        if (beat_last || resync) begin
          beat_idx      <= '0;
          frame_pending <= 1'b1;
        end else begin
          beat_idx      <= cur_idx + CNT_W'(1);
          frame_pending <= 1'b0;
        end
      end else if (resync) begin
        frame_pending <= 1'b1;
      end
    end
  end

  pfb_skid_buf #(
    .WIDTH(BUF_W)
  ) u_skid (
    .clk        (clk),
    .sync_reset (sync_reset),
    .s_tvalid   (s_axis_tvalid),
    .s_tdata    ({s_axis_tdata, beat_phase, beat_last}),
    .s_tready   (s_axis_tready),
    .m_tvalid   (m_axis_tvalid),
    .m_tdata    (buf_out),
    .m_tready   (m_axis_tready)
  );

  assign {m_axis_tdata, m_phase, m_axis_tlast} = buf_out;

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset)
      frame_cnt <= 16'd0;
    else if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
      frame_cnt <= frame_cnt + 16'd1;
  end

endmodule

// File: tb/tb_pfb_input_commutator.sv
// tb/tb_pfb_input_commutator.sv - directed self-checking bench for pfb_input_commutator
module tb_pfb_input_commutator;

  localparam int DW = 32;
  localparam int PW = 9;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic [PW:0]   num_phases;
  logic          resync;
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [PW-1:0] m_phase;
  logic [15:0]   frame_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] q_data[$];
  logic [PW-1:0] q_phase[$];
  logic          q_last[$];

  int             cyc         = 0;
  int             occ         = 0;
  int             stall_errs  = 0;
  int             ready_errs  = 0;
  int             ready_lows  = 0;
  logic           chk_ready   = 1'b0;
  logic           rand_ready  = 1'b0;
  logic           held_v      = 1'b0;
  logic [DW+PW:0] held_word   = '0;

  always #5 clk = ~clk;

  pfb_input_commutator #(
    .DATA_WIDTH  (DW),
    .PHASE_WIDTH (PW)
  ) dut (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .num_phases    (num_phases),
    .resync        (resync),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .m_phase       (m_phase),
    .frame_cnt     (frame_cnt)
  );

  // Output capture, stall-stability and occupancy model
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (sync_reset) begin
      occ    = 0;
      held_v = 1'b0;
    end else begin
      if (held_v && (!m_axis_tvalid || {m_axis_tdata, m_phase, m_axis_tlast} !== held_word))
        stall_errs = stall_errs + 1;
      held_v    = m_axis_tvalid && !m_axis_tready;
      held_word = {m_axis_tdata, m_phase, m_axis_tlast};
      if (chk_ready) begin
        if (s_axis_tready !== (occ < 2))
          ready_errs = ready_errs + 1;
        if (!s_axis_tready)
          ready_lows = ready_lows + 1;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        q_data.push_back(m_axis_tdata);
        q_phase.push_back(m_phase);
        q_last.push_back(m_axis_tlast);
      end
      occ = occ + ((s_axis_tvalid && s_axis_tready) ? 1 : 0) - ((m_axis_tvalid && m_axis_tready) ? 1 : 0);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rand_ready)
      m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_q();
    q_data.delete();
    q_phase.delete();
    q_last.delete();
  endtask

  task automatic do_reset();
    sync_reset    = 1'b1;
    s_axis_tvalid = 1'b0;
    resync        = 1'b0;
    cycle();
    cycle();
    sync_reset = 1'b0;
    cycle();
    clear_q();
  endtask

  task automatic send(input int n, input int base, input int resync_at);
    int waited;
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(base + i);
      waited = 0;
      while (!s_axis_tready && waited < 200) begin
        cycle();
        waited++;
      end
      if (waited >= 200) begin
        tests_run++;
        tests_failed++;
        $display("FAIL send_timeout: s_axis_tready stayed 0, beat %0d, required 1", i);
        s_axis_tvalid = 1'b0;
        return;
      end
      resync = (i == resync_at);
      cycle();
      resync = 1'b0;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_out(input int n, input string name);
    int budget = 0;
    while (q_data.size() < n && budget < 3000) begin
      cycle();
      budget++;
    end
    tests_run++;
    if (q_data.size() != n) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, q_data.size(), n);
    end
  endtask

  task automatic test_reset();
    sync_reset    = 1'b1;
    num_phases    = 10'd8;
    resync        = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    cycle();
    cycle();
    cycle();
    tests_run += 6;
    if (m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_tvalid: got %b, required 0", m_axis_tvalid); end
    if (m_axis_tlast !== 1'b0) begin tests_failed++; $display("FAIL rst_tlast: got %b, required 0", m_axis_tlast); end
    if (m_phase !== '0) begin tests_failed++; $display("FAIL rst_phase: got %0d, required 0", m_phase); end
    if (m_axis_tdata !== '0) begin tests_failed++; $display("FAIL rst_tdata: got %h, required 0", m_axis_tdata); end
    if (frame_cnt !== 16'd0) begin tests_failed++; $display("FAIL rst_frame_cnt: got %0d, required 0", frame_cnt); end
    if (s_axis_tready !== 1'b0) begin tests_failed++; $display("FAIL rst_tready: got %b, required 0", s_axis_tready); end
    sync_reset = 1'b0;
    cycle();
    tests_run++;
    if (s_axis_tready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_tready: got %b, required 1", s_axis_tready); end
    clear_q();
  endtask

  task automatic test_basic();
    int c0;
    int errs = 0;
    num_phases    = 10'd8;
    m_axis_tready = 1'b1;
    do_reset();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'd0;
    cycle();
    tests_run++;
    if (!(m_axis_tvalid === 1'b1 && m_axis_tdata === 32'd0 && m_phase === 9'd7 && m_axis_tlast === 1'b0)) begin
      tests_failed++;
      $display("FAIL basic_latency: got v=%b d=%0d p=%0d l=%b, required v=1 d=0 p=7 l=0",
               m_axis_tvalid, m_axis_tdata, m_phase, m_axis_tlast);
    end
    c0 = cyc;
    send(23, 1, -1);
    tests_run++;
    if (cyc - c0 != 23) begin tests_failed++; $display("FAIL basic_rate: got %0d cycles for 23 beats, required 23", cyc - c0); end
    wait_out(24, "basic");
    for (int i = 0; i < 24 && i < q_data.size(); i++) begin
      if (q_data[i] !== DW'(i) || q_phase[i] !== PW'(7 - (i % 8)) || q_last[i] !== (i % 8 == 7)) begin
        errs++;
        $display("FAIL basic_beat%0d: got d=%0d p=%0d l=%b, required d=%0d p=%0d l=%b",
                 i, q_data[i], q_phase[i], q_last[i], i, 7 - (i % 8), (i % 8 == 7));
      end
    end
    tests_run += 2;
    tests_failed += (errs != 0) ? 1 : 0;
    if (frame_cnt !== 16'd3) begin tests_failed++; $display("FAIL basic_frame_cnt: got %0d, required 3", frame_cnt); end
  endtask

  task automatic test_change();
    int exp_p[12] = '{7, 6, 5, 4, 3, 2, 1, 0, 3, 2, 1, 0};
    int errs = 0;
    num_phases    = 10'd8;
    m_axis_tready = 1'b1;
    do_reset();
    send(3, 100, -1);
    num_phases = 10'd4;
    send(9, 103, -1);
    wait_out(12, "change");
    for (int i = 0; i < 12 && i < q_data.size(); i++) begin
      if (q_data[i] !== DW'(100 + i) || q_phase[i] !== PW'(exp_p[i]) || q_last[i] !== (i == 7 || i == 11)) begin
        errs++;
        $display("FAIL change_beat%0d: got d=%0d p=%0d l=%b, required d=%0d p=%0d l=%b",
                 i, q_data[i], q_phase[i], q_last[i], 100 + i, exp_p[i], (i == 7 || i == 11));
      end
    end
    tests_run += 2;
    tests_failed += (errs != 0) ? 1 : 0;
    if (frame_cnt !== 16'd2) begin tests_failed++; $display("FAIL change_frame_cnt: got %0d, required 2", frame_cnt); end
  endtask

  task automatic test_resync();
    int ep;
    int errs = 0;
    num_phases    = 10'd16;
    m_axis_tready = 1'b1;
    do_reset();
    send(23, 200, 22);
    send(3, 223, -1);
    wait_out(26, "resync");
    for (int i = 0; i < 26 && i < q_data.size(); i++) begin
      ep = (i < 16) ? 15 - i : (i < 23) ? 15 - (i - 16) : 15 - (i - 23);
      if (q_data[i] !== DW'(200 + i) || q_phase[i] !== PW'(ep) || q_last[i] !== (i == 15)) begin
        errs++;
        $display("FAIL resync_beat%0d: got d=%0d p=%0d l=%b, required d=%0d p=%0d l=%b",
                 i, q_data[i], q_phase[i], q_last[i], 200 + i, ep, (i == 15));
      end
    end
    tests_run += 2;
    tests_failed += (errs != 0) ? 1 : 0;
    if (frame_cnt !== 16'd1) begin tests_failed++; $display("FAIL resync_frame_cnt: got %0d, required 1", frame_cnt); end
  endtask

  task automatic test_clamp();
    int ep;
    int errs = 0;
    num_phases    = 10'd0;
    m_axis_tready = 1'b1;
    do_reset();
    send(4, 300, -1);
    wait_out(4, "clamp_lo");
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      if (q_phase[i] !== PW'(1 - (i % 2)) || q_last[i] !== (i % 2 == 1)) begin
        errs++;
        $display("FAIL clamp_lo_beat%0d: got p=%0d l=%b, required p=%0d l=%b",
                 i, q_phase[i], q_last[i], 1 - (i % 2), (i % 2 == 1));
      end
    end
    tests_run += 2;
    tests_failed += (errs != 0) ? 1 : 0;
    if (frame_cnt !== 16'd2) begin tests_failed++; $display("FAIL clamp_lo_frame_cnt: got %0d, required 2", frame_cnt); end

    errs = 0;
    num_phases = 10'd1023;
    do_reset();
    send(514, 400, -1);
    wait_out(514, "clamp_hi");
    for (int i = 0; i < 514 && i < q_data.size(); i++) begin
      ep = (i < 512) ? 511 - i : 511 - (i - 512);
      if (q_data[i] !== DW'(400 + i) || q_phase[i] !== PW'(ep) || q_last[i] !== (i == 511)) begin
        errs++;
        $display("FAIL clamp_hi_beat%0d: got d=%0d p=%0d l=%b, required d=%0d p=%0d l=%b",
                 i, q_data[i], q_phase[i], q_last[i], 400 + i, ep, (i == 511));
      end
    end
    tests_run += 2;
    tests_failed += (errs != 0) ? 1 : 0;
    if (frame_cnt !== 16'd1) begin tests_failed++; $display("FAIL clamp_hi_frame_cnt: got %0d, required 1", frame_cnt); end
  endtask

  task automatic test_backpressure();
    int errs = 0;
    num_phases    = 10'd512;
    m_axis_tready = 1'b1;
    do_reset();
    stall_errs = 0;
    ready_errs = 0;
    ready_lows = 0;
    chk_ready  = 1'b1;
    rand_ready = 1'b1;
    send(1000, 1000, -1);
    wait_out(1000, "bp");
    rand_ready    = 1'b0;
    chk_ready     = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 1000 && i < q_data.size(); i++) begin
      if (q_data[i] !== DW'(1000 + i) || q_phase[i] !== PW'(511 - (i % 512)) || q_last[i] !== (i % 512 == 511))
        errs++;
    end
    tests_run += 5;
    if (errs != 0) begin tests_failed++; $display("FAIL bp_sequence: got %0d bad beats, required 0", errs); end
    if (stall_errs != 0) begin tests_failed++; $display("FAIL bp_stall_stable: got %0d changes under stall, required 0", stall_errs); end
    if (ready_errs != 0) begin tests_failed++; $display("FAIL bp_ready_vs_fill: got %0d mismatches, required 0", ready_errs); end
    if (ready_lows == 0) begin tests_failed++; $display("FAIL bp_ready_low_seen: got %0d low cycles, required >0", ready_lows); end
    if (frame_cnt !== 16'd1) begin tests_failed++; $display("FAIL bp_frame_cnt: got %0d, required 1", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    num_phases    = 10'd8;
    m_axis_tready = 1'b1;
    do_reset();
    send(11, 500, -1);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'd600;
    while (s_axis_tready && budget < 10) begin
      cycle();
      budget++;
    end
    tests_run += 2;
    if (s_axis_tready !== 1'b0) begin tests_failed++; $display("FAIL mid_full: got tready=%b, required 0", s_axis_tready); end
    if (frame_cnt !== 16'd1) begin tests_failed++; $display("FAIL mid_pre_frame_cnt: got %0d, required 1", frame_cnt); end
    #2;
    sync_reset = 1'b1;
    #1;
    tests_run += 2;
    if (m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL mid_tvalid: got %b, required 0", m_axis_tvalid); end
    if (frame_cnt !== 16'd0) begin tests_failed++; $display("FAIL mid_frame_cnt: got %0d, required 0", frame_cnt); end
    s_axis_tvalid = 1'b0;
    cycle();
    sync_reset = 1'b0;
    tests_run++;
    if (s_axis_tready !== 1'b0) begin tests_failed++; $display("FAIL mid_release_early: got tready=%b, required 0", s_axis_tready); end
    cycle();
    tests_run++;
    if (s_axis_tready !== 1'b1) begin tests_failed++; $display("FAIL mid_release_tready: got %b, required 1", s_axis_tready); end
    clear_q();
    m_axis_tready = 1'b1;
    send(1, 700, -1);
    wait_out(1, "mid");
    tests_run++;
    if (q_data.size() > 0 && (q_data[0] !== 32'd700 || q_phase[0] !== 9'd7 || q_last[0] !== 1'b0)) begin
      tests_failed++;
      $display("FAIL mid_first_beat: got d=%0d p=%0d l=%b, required d=700 p=7 l=0", q_data[0], q_phase[0], q_last[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_change();
    test_resync();
    test_clamp();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pfb_input_commutator.md
PFB_INPUT_COMMUTATOR -- requirements
Module: pfb_input_commutator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, complex sample width (I in [31:16], Q in [15:0]).
REQ-002 SHALL have parameter PHASE_WIDTH, 9, width of the phase index.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port sync_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port num_phases  input  PHASE_WIDTH+1  requested PFB arm count.
REQ-006 SHALL have port resync  input  1  single-cycle request to restart the commutator.
REQ-007 SHALL have ports s_axis_tvalid/s_axis_tdata/s_axis_tready  in/in/out  1/DATA_WIDTH/1  input sample stream.
REQ-008 SHALL have ports m_axis_tvalid/m_axis_tdata/m_axis_tlast/m_axis_tready  out/out/out/in  1/DATA_WIDTH/1/1  stream to the PFB.
REQ-009 SHALL have port m_phase  output  PHASE_WIDTH  arm index travelling with m_axis_tdata.
REQ-010 SHALL have port frame_cnt  output  16  count of completed commutator revolutions.

Function
REQ-011 SHALL latch num_phases into an active arm count at reset release, at each frame start and on resync; changes mid-frame SHALL be ignored.
REQ-012 SHALL clamp the latched arm count: values below 2 become 2, values above 2^PHASE_WIDTH become 2^PHASE_WIDTH.
REQ-013 SHALL assign the first accepted beat of a frame phase = active count - 1, then decrement by 1 per accepted beat (s_axis_tvalid & s_axis_tready).
REQ-014 SHALL mark the beat carrying phase 0 with m_axis_tlast = 1, then begin a new frame on the next accepted beat.
REQ-015 SHALL keep data, phase and tlast of one beat aligned through the output stage.
REQ-016 SHALL present an accepted beat on m_axis one cycle after acceptance when the output is empty (latency 1).
REQ-017 SHALL hold m_axis_tdata, m_phase and m_axis_tlast stable while m_axis_tvalid = 1 and m_axis_tready = 0.
REQ-018 SHALL sustain one beat per cycle with m_axis_tready held at 1.
REQ-019 SHALL drive s_axis_tready from a register.
REQ-020 SHALL hold s_axis_tready at 0 only when the 2-entry skid buffer is full.
REQ-021 SHALL make resync take effect on the next accepted beat; a beat accepted in the same cycle as resync keeps its current phase.
REQ-022 SHALL NOT assert tlast on the beat accepted in the same cycle as resync unless that beat's phase is 0.
REQ-023 SHALL reload num_phases on resync.
REQ-024 SHALL NOT drop or re-phase beats already in the skid buffer on resync.
REQ-025 SHALL increment frame_cnt by 1 when a tlast beat is accepted on the output (m_axis_tvalid & m_axis_tready & m_axis_tlast), wrapping 0xFFFF -> 0.
REQ-026 SHALL NOT reset frame_cnt on resync.
REQ-027 SHALL NOT accept or lose data when s_axis_tvalid = 0; the phase counter SHALL hold.

Reset
REQ-028 SHALL, while sync_reset = 1, drive m_axis_tvalid = 0, m_axis_tlast = 0, m_phase = 0, m_axis_tdata = 0, frame_cnt = 0 and s_axis_tready = 0.
REQ-029 SHALL empty the skid buffer and set a frame-start-pending flag in reset.
REQ-030 SHALL raise s_axis_tready on the first clock edge after reset deassertion.
REQ-031 SHALL discard in-flight beats when reset is asserted mid-operation, restarting at phase active count - 1.

Structure
REQ-032 SHALL take PFB_DATA_W = 32, PFB_PHASE_W = 9 and PFB_MAX_PHASES = 512 from shared package pfb_pkg.
REQ-033 SHALL implement the 2-entry registered handshake as sub-module pfb_skid_buf (DATA_WIDTH + PHASE_WIDTH + 1 bits wide), reusable by other PFB stages.
REQ-034 SHALL keep the phase counter, num_phases latch and frame counter in the top level; total RTL 150-300 lines.

Verification
REQ-035 Bench SHALL cover this case: num_phases = 8, continuous valid, m_axis_tready = 1 -> phases 7,6,...,0,7,...; tlast only on phase 0; frame_cnt = 3 after 24 beats.
REQ-036 Bench SHALL cover this case: num_phases changed 8 -> 4 after beat 3 of a frame -> frame completes 4,3,2,1,0; next frame runs 3,2,1,0.
REQ-037 Bench SHALL cover this case: num_phases = 16, resync pulsed with the beat at phase 9 -> that beat phase 9, tlast = 0; next beat phase 15; frame_cnt unchanged.
REQ-038 Bench SHALL cover this case: random m_axis_tready (50%) with 1000 beats of counting data, num_phases = 512 -> output data sequence intact, no duplicates, phases continuous, s_axis_tready low only when 2 entries are held.
REQ-039 Bench SHALL cover this case: num_phases = 0 and num_phases = 1023 -> arm count clamped to 2 (phases 1,0) and 512 (phases 511..0).
REQ-040 Bench SHALL cover this case: sync_reset asserted mid-frame with the buffer full -> m_axis_tvalid = 0, frame_cnt = 0 immediately; s_axis_tready = 1 one cycle after release; first beat phase = num_phases - 1.
